// File: rtl/mul_div_unit_pkg.sv
// Shared constants and encodings for the multiply/divide unit and its datapath.
// Combinational helper only; no state, no latency, no flow control.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// One iteration of the unsigned shift-add multiply / restoring divide on a 64-bit accumulator.
// Purely combinational; the caller registers o_acc_nxt once per edge.
module mul_div_iter
    import core_pkg::*;
(
    input  logic                i_is_div,
    input  logic [2*XLEN-1:0]   i_acc,
    input  logic [XLEN-1:0]     i_opnd,
    output logic [2*XLEN-1:0]   o_acc_nxt
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
        w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
        w_diff   = w_rem_sh - {1'b0, i_opnd};
        if (i_is_div) begin
            // Borrow out of the 33-bit subtract means the divisor did not fit.
            if (!w_diff[XLEN])
                o_acc_nxt = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
            else
                o_acc_nxt = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
        end else begin
            o_acc_nxt = {w_sum, i_acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed MUL/MULH/DIV/REM feeding the register file write port.
// Result pulse one cycle after the 33rd edge (after the start edge on divide-by-zero); start ignored while busy.
module mul_div_unit
    import core_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [XLEN-1:0]     read_data_1,
    input  logic [XLEN-1:0]     read_data_2,
    input  logic [REG_AW-1:0]   dest_reg,
    output logic                busy,
    output logic                write_enable,
    output logic [REG_AW-1:0]   write_reg,
    output logic [XLEN-1:0]     write_data,
    output logic                div_by_zero
);

    state_t             r_state;
    state_t             w_state_nxt;
    op_t                r_op;
    logic [REG_AW-1:0]  r_dest;
    logic               r_sign;
    logic               r_dbz;
    logic [4:0]         r_count;
    logic [2*XLEN-1:0]  r_acc;
    logic [XLEN-1:0]    r_opnd;
    logic [XLEN-1:0]    r_result;

    op_t                w_op_in;
    logic               w_in_div;
    logic               w_in_dbz;
    logic               w_is_div;
    logic               w_last;
    logic [2*XLEN-1:0]  w_acc_nxt;
    logic [2*XLEN-1:0]  w_prod_s;
    logic [XLEN-1:0]    w_quo_s;
    logic [XLEN-1:0]    w_rem_s;
    logic [XLEN-1:0]    w_fixed;

    assign w_op_in  = op_t'(op);
    assign w_in_div = (w_op_in == OP_DIV) || (w_op_in == OP_REM);
    assign w_in_dbz = w_in_div && (read_data_2 == '0);
    assign w_is_div = (r_op == OP_DIV) || (r_op == OP_REM);
    assign w_last   = (r_count == 5'd31);

    mul_div_iter u_iter (
        .i_is_div  (w_is_div),
        .i_acc     (r_acc),
        .i_opnd    (r_opnd),
        .o_acc_nxt (w_acc_nxt)
    );

    // Sign fix applied to the final iteration's output so it lands on the DONE edge.
    always_comb begin
        w_prod_s = r_sign ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
        w_quo_s  = r_sign ? (~w_acc_nxt[XLEN-1:0] + 1'b1) : w_acc_nxt[XLEN-1:0];
        w_rem_s  = r_sign ? (~w_acc_nxt[2*XLEN-1:XLEN] + 1'b1) : w_acc_nxt[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:  w_fixed = w_prod_s[XLEN-1:0];
            OP_MULH: w_fixed = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV:  w_fixed = w_quo_s;
            default: w_fixed = w_rem_s;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = w_in_dbz ? ST_DONE : ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != ST_IDLE);
        write_enable = (r_state == ST_DONE) && (r_dest != '0);
        div_by_zero  = (r_state == ST_DONE) && r_dbz;
        write_reg    = r_dest;
        write_data   = r_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_dest   <= '0;
            r_sign   <= 1'b0;
            r_dbz    <= 1'b0;
            r_count  <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= w_op_in;
                        r_dest  <= dest_reg;
                        r_count <= '0;
                        r_dbz   <= w_in_dbz;
                        r_sign  <= (w_op_in == OP_REM) ? read_data_1[XLEN-1]
                                                       : (read_data_1[XLEN-1] ^ read_data_2[XLEN-1]);
                        if (w_in_div) begin
                            r_acc  <= {{XLEN{1'b0}}, abs_val(read_data_1)};
                            r_opnd <= abs_val(read_data_2);
                        end else begin
                            r_acc  <= {{XLEN{1'b0}}, abs_val(read_data_2)};
                            r_opnd <= abs_val(read_data_1);
                        end
                        if (w_in_dbz)
                            r_result <= (w_op_in == OP_DIV) ? {XLEN{1'b1}} : read_data_1;
                    end
                end
                ST_RUN: begin
                    r_acc   <= w_acc_nxt;
                    r_count <= r_count + 5'd1;
                    if (w_last) r_result <= w_fixed;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    import core_pkg::*;

    logic               clk;
    logic               rst;
    logic               start;
    logic [1:0]         op;
    logic [XLEN-1:0]    read_data_1;
    logic [XLEN-1:0]    read_data_2;
    logic [REG_AW-1:0]  dest_reg;
    logic               busy;
    logic               write_enable;
    logic [REG_AW-1:0]  write_reg;
    logic [XLEN-1:0]    write_data;
    logic               div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    mul_div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .read_data_1  (read_data_1),
        .read_data_2  (read_data_2),
        .dest_reg     (dest_reg),
        .busy         (busy),
        .write_enable (write_enable),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .div_by_zero  (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs after the start edge, optionally re-pulse
    // start at edge poke, then watch 40 cycles for the single write pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp_data,
                          input logic exp_dbz, input int exp_lat, input int exp_busy, input int poke);
        int          lat;
        int          busy_cnt;
        int          pulses;
        logic [31:0] got_data;
        logic [4:0]  got_reg;
        logic        got_dbz;
        lat = -1; busy_cnt = 0; pulses = 0;
        got_data = 'x; got_reg = 'x; got_dbz = 1'bx;
        @(negedge clk);
        op = o; read_data_1 = a; read_data_2 = b; dest_reg = d; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        read_data_1 = $urandom; read_data_2 = $urandom; dest_reg = 5'($urandom); op = 2'($urandom);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (write_enable) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; got_data = write_data; got_reg = write_reg; got_dbz = div_by_zero;
                end
            end
            if (k == poke - 1) begin
                start = 1'b1; op = OP_DIV; read_data_1 = 32'd100; read_data_2 = 32'd3; dest_reg = 5'd9;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(busy_cnt), 64'(exp_busy));
        if (exp_lat >= 0) begin
            chk({tag, "_pulses"}, 64'(pulses), 64'd1);
            chk({tag, "_data"}, 64'(got_data), 64'(exp_data));
            chk({tag, "_reg"}, 64'(got_reg), 64'(d));
            chk({tag, "_dbz"}, 64'(got_dbz), 64'(exp_dbz));
        end else begin
            chk({tag, "_pulses"}, 64'(pulses), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00;
        read_data_1 = '0; read_data_2 = '0; dest_reg = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_wreg", 64'(write_reg), 64'd0);
        chk("rst_wdata", 64'(write_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_5x23",     OP_MUL,  32'd5,          32'd23,         5'd3, 32'd115,      1'b0, 32, 33, -1);
        run_op("div_23_5",     OP_DIV,  32'd23,         32'd5,          5'd4, 32'd4,        1'b0, 32, 33, -1);
        run_op("rem_23_5",     OP_REM,  32'd23,         32'd5,          5'd5, 32'd3,        1'b0, 32, 33, -1);
        run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd6, 32'hFFFF_FFFD, 1'b0, 32, 33, -1);
        run_op("rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd7, 32'hFFFF_FFFF, 1'b0, 32, 33, -1);
        run_op("mulh_min_min", OP_MULH, 32'h8000_0000,  32'h8000_0000,  5'd8, 32'h4000_0000, 1'b0, 32, 33, -1);
        run_op("mul_min_min",  OP_MUL,  32'h8000_0000,  32'h8000_0000,  5'd8, 32'h0,        1'b0, 32, 33, -1);
        run_op("mulh_m1_1",    OP_MULH, 32'hFFFF_FFFF,  32'd1,          5'd9, 32'hFFFF_FFFF, 1'b0, 32, 33, -1);
        run_op("mul_m3_7",     OP_MUL,  32'hFFFF_FFFD,  32'd7,          5'd10, 32'hFFFF_FFEB, 1'b0, 32, 33, -1);
        run_op("div_by_0",     OP_DIV,  32'd23,         32'd0,          5'd11, 32'hFFFF_FFFF, 1'b1, 0, 1, -1);
        run_op("rem_by_0",     OP_REM,  32'd23,         32'd0,          5'd12, 32'd23,       1'b1, 0, 1, -1);
        run_op("mul_poke5",    OP_MUL,  32'd5,          32'd23,         5'd13, 32'd115,      1'b0, 32, 33, 5);
        run_op("div_min_m1",   OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h8000_0000, 1'b0, 32, 33, -1);
        run_op("rem_min_m1",   OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h0,        1'b0, 32, 33, -1);

        // Reset in the middle of a MUL: outputs clear at once, no pulse afterwards.
        begin
            int pulses;
            pulses = 0;
            @(negedge clk);
            op = OP_MUL; read_data_1 = 32'd6; read_data_2 = 32'd7; dest_reg = 5'd20; start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (9) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            chk("midrst_busy", 64'(busy), 64'd0);
            chk("midrst_we", 64'(write_enable), 64'd0);
            chk("midrst_wreg", 64'(write_reg), 64'd0);
            chk("midrst_wdata", 64'(write_data), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (write_enable) pulses++;
            end
            chk("midrst_pulses", 64'(pulses), 64'd0);
        end

        run_op("mul_dest0",    OP_MUL,  32'd5,          32'd23,         5'd0, 32'd115,      1'b0, -1, 33, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
